scope_capture_buffer: RTL and testbench

- Writer side of the oscilloscope sample buffer consumed by the VGA trace renderer.
- Accepts a 12-bit ADC sample stream and waits for a level/slope trigger, then captures DEPTH samples into a back buffer.
- Publishes the back buffer to the front array `data_display` only during vertical blanking, so the renderer never draws a half-updated trace.
- Sits between the ADC interface and `draw_display`, in the same `clk` domain.

---
 rtl/vga_pkg.sv | 16 +
 rtl/trigger_detect.sv | 68 ++++++
 rtl/scope_capture_buffer.sv | 169 ++++++++++++++++
 tb/tb_scope_capture_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scope definitions.
// Capture FSM states and trace buffer geometry reused by draw_display.
package vga_pkg;

  localparam int SCOPE_DEPTH  = 512;
  localparam int SCOPE_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    PUBLISH,
    HOLD
  } capture_state_e;

endpackage

// File: rtl/trigger_detect.sv
// Level/slope trigger for the scope capture buffer.
// Ports: clk, rst, en (ARMED), sample_valid/sample_data, trig_level,
//   trig_slope, trig_auto in; trig_hit, trig_forced out.
module trigger_detect
  import vga_pkg::*;
#(
  parameter int DATA_W       = SCOPE_DATA_W,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              trig_auto,
  output logic              trig_hit,
  output logic              trig_forced
);

  localparam int CW = $clog2(AUTO_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(AUTO_TIMEOUT - 1);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              pv_q, pv_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rise, fall, level_hit, to_hit;

  // History and timeout are cleared whenever not armed, so
  // every arming starts without a stale previous sample.
  always_comb begin
    prev_d = prev_q;
    pv_d   = pv_q;
    cnt_d  = cnt_q;
    if (!en) begin
      pv_d  = 1'b0;
      cnt_d = '0;
    end else if (sample_valid) begin
      prev_d = sample_data;
      pv_d   = 1'b1;
      if (cnt_q != TO_LAST) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pv_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      pv_q   <= pv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rise = pv_q && (prev_q < trig_level)
             && (sample_data >= trig_level);
  assign fall = pv_q && (prev_q > trig_level)
             && (sample_data <= trig_level);
  assign level_hit = trig_slope ? fall : rise;
  assign to_hit    = trig_auto && (cnt_q == TO_LAST);

  assign trig_hit    = en && sample_valid && (level_hit || to_hit);
  assign trig_forced = trig_hit && !level_hit;

endmodule

// File: rtl/scope_capture_buffer.sv
// Scope capture buffer: trigger, capture DEPTH samples, publish on vblank.
// Ports: clk, rst, sample_valid/sample_data, trig_level/slope/auto, run,
//   vblnk in; data_display[0:DEPTH-1], busy, frame_pub, forced out.
// Option SCOPE_CAPTURE_DECIMATE_EN adds decim[3:0] (store every decim+1).
module scope_capture_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH        = SCOPE_DEPTH,
  parameter int DATA_W       = SCOPE_DATA_W,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int HOLDOFF      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              trig_auto,
  input  logic              run,
  input  logic              vblnk,
`ifdef SCOPE_CAPTURE_DECIMATE_EN
  input  logic [3:0]        decim,
`endif
  output logic [DATA_W-1:0] data_display [0:DEPTH-1],
  output logic              busy,
  output logic              frame_pub,
  output logic              forced
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);

  capture_state_e    state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              ff_q, ff_d;
  logic              forced_q, forced_d;
  logic              vblnk_q;
  logic [DATA_W-1:0] back_q [0:DEPTH-1];
  logic              wr_en, publish, take;
  logic [AW-1:0]     wr_addr;
  logic              trig_hit, trig_forced;

  trigger_detect #(
    .DATA_W       (DATA_W),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trig (
    .clk          (clk),
    .rst          (rst),
    .en           (state_q == ARMED),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .trig_auto    (trig_auto),
    .trig_hit     (trig_hit),
    .trig_forced  (trig_forced)
  );

`ifdef SCOPE_CAPTURE_DECIMATE_EN
  logic [3:0] dec_q, dec_d;

  // Phase counter restarts at the trigger sample, which is stored.
  always_comb begin
    dec_d = dec_q;
    take  = 1'b0;
    if (state_q == ARMED && trig_hit) begin
      dec_d = '0;
    end else if (state_q == CAPTURE && sample_valid) begin
      take  = (dec_q == decim);
      dec_d = take ? 4'd0 : dec_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_q <= '0;
    else     dec_q <= dec_d;
  end
`else
  assign take = sample_valid;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    hold_d   = hold_q;
    ff_d     = ff_q;
    forced_d = forced_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    publish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = ARMED;
      end
      ARMED: begin
        if (!run) begin
          state_d = IDLE;
        end else if (trig_hit) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = AW'(1);
          ff_d     = trig_forced;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (take) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(DEPTH - 1)) state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        // Edge, not level: a vblank already in progress is skipped.
        if (vblnk && !vblnk_q) begin
          publish  = 1'b1;
          forced_d = ff_q;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HW'(HOLDOFF - 1)) begin
          state_d = run ? ARMED : IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      hold_q   <= '0;
      ff_q     <= 1'b0;
      forced_q <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      hold_q   <= hold_d;
      ff_q     <= ff_d;
      forced_q <= forced_d;
      vblnk_q  <= vblnk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        back_q[i]       <= '0;
        data_display[i] <= '0;
      end
    end else begin
      if (wr_en) back_q[wr_addr] <= sample_data;
      if (publish) data_display <= back_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign frame_pub = publish;
  assign forced    = forced_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Bench for scope_capture_buffer.
// Expected frames are queued as stimulus is driven, checked on publish.
module tb_scope_capture_buffer;
  import vga_pkg::*;

  localparam int DEPTH = SCOPE_DEPTH;
  localparam int DW    = SCOPE_DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic          trig_auto = 1'b0;
  logic          run = 1'b0;
  logic          vblnk = 1'b0;
  logic [DW-1:0] data_display [0:DEPTH-1];
  logic          busy, frame_pub, forced;

  int checks = 0;
  int errors = 0;
  int pub_cnt = 0;
  int mism;
  logic [DW-1:0] e, e0, el;
  logic [DW-1:0] exp_q [$];
  logic          exp_f_q [$];

  always #5 clk = ~clk;

  scope_capture_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .trig_auto    (trig_auto),
    .run          (run),
    .vblnk        (vblnk),
    .data_display (data_display),
    .busy         (busy),
    .frame_pub    (frame_pub),
    .forced       (forced)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic push_ramp;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'(2048 + 8 * i));
    exp_f_q.push_back(1'b0);
  endtask

  task automatic vblank_pulse;
    vblnk = 1'b1;
    repeat (3) tick();
    vblnk = 1'b0;
    tick();
  endtask

  // Scoreboard: one cycle after a publish pulse, the front buffer
  // must hold the oldest queued frame.
  initial forever begin
    @(negedge clk);
    if (frame_pub === 1'b1) begin
      pub_cnt++;
      @(negedge clk);
      check("pub_one_cycle", {31'd0, frame_pub}, 0);
      if (exp_q.size() < DEPTH || exp_f_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), DEPTH);
      end else begin
        mism = 0;
        e0 = '0;
        el = '0;
        for (int i = 0; i < DEPTH; i++) begin
          e = exp_q.pop_front();
          if (i == 0) e0 = e;
          if (i == DEPTH - 1) el = e;
          if (data_display[i] !== e) mism++;
        end
        check("disp_first", {20'd0, data_display[0]}, {20'd0, e0});
        check("disp_last", {20'd0, data_display[DEPTH-1]}, {20'd0, el});
        check("frame_words", mism, 0);
        check("forced", {31'd0, forced}, {31'd0, exp_f_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pub", {31'd0, frame_pub}, 0);
    check("rst_forced", {31'd0, forced}, 0);
    check("rst_disp0", {20'd0, data_display[0]}, 0);
    check("rst_displast", {20'd0, data_display[DEPTH-1]}, 0);

    // Rising ramp, invalid garbage between samples
    trig_level = 12'd2048;
    trig_slope = 1'b0;
    trig_auto  = 1'b0;
    run        = 1'b1;
    rst        = 1'b0;
    tick();
    check("armed_busy", {31'd0, busy}, 1);
    push_ramp();
    for (int k = 0; k < 768; k++) begin
      send(DW'(k * 8));
      sample_data = 12'hABC;
      tick();
    end
    repeat (3) tick();
    check("no_pub_wo_vblnk", pub_cnt, 0);
    vblank_pulse();
    check("pub_cnt_ramp", pub_cnt, 1);
    repeat (70) tick();

    // Falling slope, vblnk held high across end of capture
    trig_slope = 1'b1;
    trig_level = 12'd1000;
    vblnk      = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DW'(1000 - i));
    exp_f_q.push_back(1'b0);
    send(12'd900);
    send(12'd1200);
    send(12'd1100);
    for (int i = 0; i < DEPTH; i++) send(DW'(1000 - i));
    repeat (5) send(12'd7);
    repeat (5) tick();
    check("no_pub_vblnk_held", pub_cnt, 1);
    vblnk = 1'b0;
    repeat (2) tick();
    vblank_pulse();
    check("pub_cnt_fall", pub_cnt, 2);
    repeat (70) tick();

    // Auto mode: forced trigger on the 4096th valid sample
    trig_slope = 1'b0;
    trig_level = 12'd2048;
    trig_auto  = 1'b1;
    exp_q.push_back(12'd101);
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(12'd100);
    exp_f_q.push_back(1'b1);
    repeat (4095) send(12'd100);
    send(12'd101);
    repeat (DEPTH - 1) send(12'd100);
    repeat (3) tick();
    vblank_pulse();
    check("pub_cnt_auto", pub_cnt, 3);
    repeat (70) tick();

    // Normal mode never times out
    trig_auto = 1'b0;
    repeat (4200) send(12'd100);
    check("armed_stays_busy", {31'd0, busy}, 1);
    check("pub_cnt_normal", pub_cnt, 3);
    run = 1'b0;
    tick();
    check("armed_run0_idle", {31'd0, busy}, 0);

    // Reset during capture with wr_ptr at 200
    run = 1'b1;
    tick();
    check("rearm_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 456; k++) send(DW'(k * 8));
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 0);
    tick();
    check("rst_cap_busy", {31'd0, busy}, 0);
    check("rst_cap_pub", {31'd0, frame_pub}, 0);
    check("rst_cap_forced", {31'd0, forced}, 0);
    check("rst_cap_disp0", {20'd0, data_display[0]}, 0);
    check("rst_cap_disp300", {20'd0, data_display[300]}, 0);
    rst = 1'b0;
    tick();
    check("armed_after_rst", {31'd0, busy}, 1);

    // run dropped mid capture: publish, hold, then idle
    push_ramp();
    for (int k = 0; k < 768; k++) begin
      if (k == 400) run = 1'b0;
      send(DW'(k * 8));
    end
    tick();
    vblnk = 1'b1;
    tick();
    vblnk = 1'b0;
    repeat (63) tick();
    check("hold_busy", {31'd0, busy}, 1);
    tick();
    check("idle_after_hold", {31'd0, busy}, 0);
    check("pub_cnt_rundrop", pub_cnt, 4);
    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
